// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register for the 5-stage MIPS core: payload, pc/bd/excode/valid tracking.
// Optional performance counters are built when PIPE_STAGE_PERF_EN is defined.
module pipe_stage_reg #(
   parameter int unsigned NCH        = 5,
   parameter int unsigned WIDTH      = 32,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180,
   parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   we,
   input  logic                   flush,
   input  logic                   req,
   input  logic [31:0]            pc_in,
   input  logic [31:0]            instr_in,
   input  logic                   bd_in,
   input  logic [4:0]             excode_in,
   input  logic [4:0]             exc_local,
   input  logic [NCH*WIDTH-1:0]   data_in,
   output logic [31:0]            pc_out,
   output logic [31:0]            instr_out,
   output logic                   bd_out,
   output logic [4:0]             excode_out,
   output logic                   valid_out,
   output logic [NCH*WIDTH-1:0]   data_out,
   output logic [31:0]            stall_cnt,
   output logic [31:0]            bubble_cnt
);

   // The exception raised by an older instruction/stage takes precedence.
   function automatic logic [4:0] merge_exc(input logic [4:0] e_in, input logic [4:0] e_loc);
      return (e_in != 5'd0) ? e_in : e_loc;
   endfunction

   logic [31:0]          pc_q, pc_d;
   logic [31:0]          instr_q, instr_d;
   logic                 bd_q, bd_d;
   logic [4:0]           excode_q, excode_d;
   logic                 valid_q, valid_d;
   logic [NCH*WIDTH-1:0] data_q, data_d;

   // Next-state selection: reset > req > flush > stall > load.
   always_comb begin
      pc_d     = pc_q;
      instr_d  = instr_q;
      bd_d     = bd_q;
      excode_d = excode_q;
      valid_d  = valid_q;
      data_d   = data_q;
      if (reset) begin
         pc_d     = RESET_PC;
         instr_d  = 32'd0;
         bd_d     = 1'b0;
         excode_d = 5'd0;
         valid_d  = 1'b0;
         data_d   = {(NCH*WIDTH){1'b0}};
      end else if (req) begin
         pc_d     = HANDLER_PC;
         instr_d  = 32'd0;
         bd_d     = 1'b0;
         excode_d = 5'd0;
         valid_d  = 1'b0;
         data_d   = {(NCH*WIDTH){1'b0}};
      end else if (flush) begin
         // Bubble keeps pc/bd so a later exception can still compute EPC.
         pc_d     = pc_in;
         instr_d  = 32'd0;
         bd_d     = bd_in;
         excode_d = 5'd0;
         valid_d  = 1'b0;
         data_d   = {(NCH*WIDTH){1'b0}};
      end else if (we) begin
         pc_d     = pc_in;
         instr_d  = instr_in;
         bd_d     = bd_in;
         excode_d = merge_exc(excode_in, exc_local);
         valid_d  = 1'b1;
         data_d   = data_in;
      end else begin
         pc_d     = pc_q;
         instr_d  = instr_q;
         bd_d     = bd_q;
         excode_d = excode_q;
         valid_d  = valid_q;
         data_d   = data_q;
      end
   end

   // Stage register.
   always_ff @(posedge clk) begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      bd_q     <= bd_d;
      excode_q <= excode_d;
      valid_q  <= valid_d;
      data_q   <= data_d;
   end

   assign pc_out     = pc_q;
   assign instr_out  = instr_q;
   assign bd_out     = bd_q;
   assign excode_out = excode_q;
   assign valid_out  = valid_q;
   assign data_out   = data_q;

`ifdef PIPE_STAGE_PERF_EN
   logic [31:0] stall_cnt_q, stall_cnt_d;
   logic [31:0] bubble_cnt_q, bubble_cnt_d;

   // Counters wrap naturally at 32 bits; only reset clears them.
   always_comb begin
      stall_cnt_d  = stall_cnt_q;
      bubble_cnt_d = bubble_cnt_q;
      if (reset) begin
         stall_cnt_d  = 32'd0;
         bubble_cnt_d = 32'd0;
      end else if (req || flush) begin
         bubble_cnt_d = bubble_cnt_q + 32'd1;
      end else if (!we) begin
         stall_cnt_d  = stall_cnt_q + 32'd1;
      end else begin
         stall_cnt_d  = stall_cnt_q;
         bubble_cnt_d = bubble_cnt_q;
      end
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      stall_cnt_q  <= stall_cnt_d;
      bubble_cnt_q <= bubble_cnt_d;
   end

   assign stall_cnt  = stall_cnt_q;
   assign bubble_cnt = bubble_cnt_q;
`else
   assign stall_cnt  = 32'd0;
   assign bubble_cnt = 32'd0;
`endif

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
- Generic, parametrised inter-stage pipeline register for the 5-stage MIPS CPU with exception/interrupt support. Intended for D/E/M/W boundaries.
- Carries NCH data channels plus per-instruction control: pc, instr, valid, branch-delay flag, exception code.
- Supports stall (hold), bubble insertion (flush keeping pc/bd for EPC), exception-request flush to the handler PC, and first-wins merge of exception codes.

Parameters:
- NCH, 5, number of generic data channels (AO, RD, EXT32, MDUO, CP0OUT, ...), 1..16
- WIDTH, 32, width of each data channel in bits
- HANDLER_PC, 32'h0000_4180, pc loaded on exception request
- RESET_PC, 32'h0000_0000, pc value after reset

Ports:
- clk  in  1  clock, all state updates on posedge
- reset  in  1  synchronous, active-high reset
- we  in  1  load enable; 0 = stall/hold
- flush  in  1  insert bubble (clear payload, keep pc_in/bd_in)
- req  in  1  exception/interrupt request; flush to handler
- pc_in  in  32  instruction pc
- instr_in  in  32  instruction word
- bd_in  in  1  instruction is in a branch delay slot
- excode_in  in  5  exception code from earlier stages, 0 = none
- exc_local  in  5  exception code detected in the feeding stage, 0 = none
- data_in  in  NCH*WIDTH  channel k at bits [k*WIDTH +: WIDTH]
- pc_out  out  32  registered pc
- instr_out  out  32  registered instruction
- bd_out  out  1  registered delay-slot flag
- excode_out  out  5  registered merged exception code
- valid_out  out  1  1 = real instruction, 0 = bubble
- data_out  out  NCH*WIDTH  registered channels, same packing as data_in
- stall_cnt  out  32  cycles with we=0 (optional feature)
- bubble_cnt  out  32  cycles with flush or req taken (optional feature)

Behaviour:
- All outputs are registered. Latency is 1 cycle. Nothing combinational from inputs to outputs.
- Priority per posedge: reset > req > flush > !we > load.
- reset:
  - pc_out=RESET_PC.
  - instr_out, data_out, excode_out, bd_out, valid_out = 0.
  - Counters = 0.
- req=1 (regardless of we/flush):
  - pc_out=HANDLER_PC.
  - instr, data, excode, bd = 0; valid_out=0.
- flush=1, req=0:
  - pc_out=pc_in, bd_out=bd_in.
  - instr, data, excode = 0; valid_out=0.
  - Flush overrides stall: bubble is inserted even when we=0.
- we=0, no flush/req: every register holds its value.
- Load (we=1):
  - All fields take their _in values; valid_out=1.
  - excode_out = (excode_in!=0) ? excode_in : exc_local. The earlier-stage exception wins.
- Exactly one of the four actions applies per cycle. No partial updates.
- When NCH=1, data_in and data_out are WIDTH bits wide. Unused parameter ranges are illegal; no runtime check.

Optional Feature:
- PIPE_STAGE_PERF_EN defined:
  - stall_cnt increments by 1 on every non-reset cycle with we=0 and req=0 and flush=0.
  - bubble_cnt increments by 1 on every non-reset cycle with req=1 or flush=1.
  - Both are 32-bit, wrap 0xFFFF_FFFF -> 0, and are cleared only by reset.
- Not defined: stall_cnt and bubble_cnt are tied to 0 and no counter logic is generated.

Test Plan:
- Reset: assert reset 1 cycle with arbitrary inputs -> pc_out=0, instr_out=0, data_out=0, excode_out=0, valid_out=0, bd_out=0.
- Load/stall:
  - Load pc_in=0x3004, instr_in=0x8C010004, ch0=0x1234 with we=1 -> next cycle outputs match, valid_out=1.
  - Then we=0 for 3 cycles with changed inputs -> outputs unchanged; stall_cnt=3 when PIPE_STAGE_PERF_EN is defined.
- Exception request: req=1 together with flush=1 and we=0, pc_in=0x3010 -> pc_out=0x0000_4180, instr_out=0, valid_out=0, bd_out=0; bubble_cnt=1.
- Flush during stall: flush=1, we=0, pc_in=0x3020, bd_in=1 -> pc_out=0x3020, bd_out=1, instr_out=0, data_out=0, valid_out=0.
- Exception merge:
  - excode_in=4, exc_local=10, we=1 -> excode_out=4.
  - Next load with excode_in=0, exc_local=12 -> excode_out=12.
- Parametrised build: NCH=3, WIDTH=16, HANDLER_PC=0x8000_0180 -> channel k=2 at data_in[47:32]=0xBEEF appears at data_out[47:32].
  - req then yields pc_out=0x8000_0180.
  - With PIPE_STAGE_PERF_EN, stall_cnt preloaded near 0xFFFF_FFFF wraps to 0 after one more stall.
